// File: rtl/cell_blit_scheduler.sv
// Two-requester character-cell blitter: round-robin grant, then a walk over the
// cell's pixels reading a 1-bit glyph ROM and issuing one framebuffer write per cycle.
module cell_blit_scheduler #(
  parameter int unsigned CELL_W   = 10,
  parameter int unsigned CELL_H   = 10,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned GLYPH_W  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a_valid,
  input  logic [5:0]         req_a_x,
  input  logic [5:0]         req_a_y,
  input  logic [GLYPH_W-1:0] req_a_glyph,
  output logic               req_a_ready,
  input  logic               req_b_valid,
  input  logic [5:0]         req_b_x,
  input  logic [5:0]         req_b_y,
  input  logic [GLYPH_W-1:0] req_b_glyph,
  output logic               req_b_ready,
  output logic [13:0]        rom_addr,
  input  logic               rom_data,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic               fb_data,
  output logic               fb_we,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [5:0]        MAX_Y      = 6'd47;
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W * CELL_H);
  localparam logic [ADDR_W-1:0] CELL_STEP  = ADDR_W'(CELL_W);
  localparam logic [ADDR_W-1:0] ROW_WRAP   = ADDR_W'(SCREEN_W - CELL_W + 1);
  localparam logic [13:0]       GLYPH_SIZE = 14'(CELL_W * CELL_H);
  localparam logic [3:0]        LAST_COL   = 4'(CELL_W - 1);
  localparam logic [3:0]        LAST_ROW   = 4'(CELL_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_BASE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               prio_a_q, prio_a_d;   // 1: A wins when both are valid
  logic [5:0]         x_q, y_q;
  logic [GLYPH_W-1:0] glyph_q;
  logic [3:0]         row_q, col_q;
  logic [ADDR_W-1:0]  pix_q, fb_addr_q;
  logic [13:0]        rom_q;
  logic               fb_we_q, err_q;

  logic               idle, grant_a, grant_b, accept, req_ok, last_pix;
  logic [5:0]         sel_x, sel_y;
  logic [GLYPH_W-1:0] sel_glyph;

  assign sel_x     = grant_a ? req_a_x : req_b_x;
  assign sel_y     = grant_a ? req_a_y : req_b_y;
  assign sel_glyph = grant_a ? req_a_glyph : req_b_glyph;
  assign accept    = grant_a | grant_b;
  assign req_ok    = (sel_x != 6'd0) && (sel_y != 6'd0) && (sel_y <= MAX_Y);
  assign last_pix  = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // State and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prio_a_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      prio_a_q <= prio_a_d;
    end
  end

  // Next-state and pointer update; invalid requests are consumed without leaving IDLE
  always_comb begin
    state_d  = state_q;
    prio_a_d = prio_a_q;
    if (grant_a) prio_a_d = 1'b0;
    else if (grant_b) prio_a_d = 1'b1;
    case (state_q)
      S_IDLE:  if (accept && req_ok) state_d = S_BASE;
      S_BASE:  state_d = S_RUN;
      S_RUN:   if (last_pix) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    idle        = (state_q == S_IDLE);
    grant_a     = idle && req_a_valid && (!req_b_valid || prio_a_q);
    grant_b     = idle && req_b_valid && (!req_a_valid || !prio_a_q);
    req_a_ready = grant_a;
    req_b_ready = grant_b;
    busy        = !idle;
    done        = (state_q == S_DRAIN);
  end

  // Request latch, pixel walk and registered write stage (one cycle behind the ROM address)
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      glyph_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pix_q     <= '0;
      rom_q     <= '0;
      fb_addr_q <= '0;
      fb_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fb_we_q <= (state_q == S_RUN);
      err_q   <= accept && !req_ok;
      if (state_q == S_RUN) fb_addr_q <= pix_q;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q     <= sel_x;
            y_q     <= sel_y;
            glyph_q <= sel_glyph;
          end
        end
        S_BASE: begin
          pix_q <= ADDR_W'(y_q) * ROW_STRIDE + ADDR_W'(x_q) * CELL_STEP;
          rom_q <= 14'(glyph_q) * GLYPH_SIZE;
          row_q <= '0;
          col_q <= '0;
        end
        S_RUN: begin
          // Hold on the final pixel so rom_addr never passes the glyph's last entry
          if (!last_pix) begin
            rom_q <= rom_q + 14'd1;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 4'd1;
              pix_q <= pix_q + ROW_WRAP;
            end else begin
              col_q <= col_q + 4'd1;
              pix_q <= pix_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr = rom_q;
  assign fb_addr  = fb_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_data  = fb_we_q & rom_data;
  assign err      = err_q;

endmodule

// File: tb/tb_cell_blit_scheduler.sv
// Self-checking bench for cell_blit_scheduler: per-cycle reference model of grants,
// write schedule and pulses, a vector table of single cells, and multi-cycle sequences.
module tb_cell_blit_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [5:0]  req_a_x = '0, req_a_y = '0, req_b_x = '0, req_b_y = '0;
  logic [6:0]  req_a_glyph = '0, req_b_glyph = '0;
  logic        req_a_ready, req_b_ready;
  logic [13:0] rom_addr;
  logic        rom_data = 1'b0;
  logic [18:0] fb_addr;
  logic        fb_data, fb_we, busy, done, err;

  cell_blit_scheduler dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_x(req_a_x), .req_a_y(req_a_y),
    .req_a_glyph(req_a_glyph), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_x(req_b_x), .req_b_y(req_b_y),
    .req_b_glyph(req_b_glyph), .req_b_ready(req_b_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Glyph ROM model: registered read, data one cycle after the address
  bit mem [0:12799];
  always @(posedge clk) rom_data <= (rom_addr < 14'd12800) ? mem[rom_addr] : 1'b0;

  typedef struct { int cyc; int addr; int rom; bit last; } wr_t;
  typedef struct { int cyc; int addr; } log_t;
  typedef struct { bit side_b; int x; int y; int g; bit ok; int first; int last; } vec_t;

  wr_t  exp_q[$];
  log_t wr_log[$];
  int   grant_log[$];
  int   n_err_seen = 0, n_done_seen = 0;
  int   cyc = 0, free_cyc = 0, err_due = -1, prev_rom = 0;
  bit   fav_a = 1'b1, rst_at_edge = 1'b1, granted_a = 1'b0, granted_b = 1'b0;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: a grant in cycle c writes pixel k at cycle c+3+k and frees the
  // block at c+103; an invalid grant pulses err at c+1 and frees the block at c+1.
  task automatic monitor();
    bit  idle, ea, eb, have, gok;
    int  gx, gy, gg;
    wr_t e;
    if (rst_at_edge) begin
      exp_q.delete();
      fav_a = 1'b1; free_cyc = cyc; err_due = -1;
    end
    idle = (cyc >= free_cyc);
    ea = idle && req_a_valid && (!req_b_valid || fav_a);
    eb = idle && req_b_valid && (!req_a_valid || !fav_a);
    chk("ready_a", 32'(req_a_ready), 32'(ea));
    chk("ready_b", 32'(req_b_ready), 32'(eb));
    chk("busy", 32'(busy), 32'(!idle));
    chk("err", 32'(err), 32'(cyc == err_due));
    have = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("fb_we", 32'(fb_we), 32'(have));
    if (fb_we) wr_log.push_back('{cyc, int'(fb_addr)});
    if (done) n_done_seen++;
    if (err) n_err_seen++;
    if (have) begin
      e = exp_q.pop_front();
      chk("fb_addr", 32'(fb_addr), e.addr);
      chk("rom_addr_prev", prev_rom, e.rom);
      chk("fb_data", 32'(fb_data), 32'(mem[e.rom]));
      chk("done", 32'(done), 32'(e.last));
    end else begin
      chk("done_idle", 32'(done), 32'd0);
    end
    granted_a = req_a_valid && req_a_ready;
    granted_b = req_b_valid && req_b_ready;
    if (ea || eb) begin
      gx = ea ? int'(req_a_x) : int'(req_b_x);
      gy = ea ? int'(req_a_y) : int'(req_b_y);
      gg = ea ? int'(req_a_glyph) : int'(req_b_glyph);
      grant_log.push_back(ea ? 0 : 1);
      fav_a = eb;
      gok = (gx != 0) && (gy != 0) && (gy <= 47);
      if (gok) begin
        for (int k = 0; k < 100; k++)
          exp_q.push_back('{cyc + 3 + k, (gy * 10 + k / 10) * 640 + gx * 10 + k % 10,
                            gg * 100 + k, k == 99});
        free_cyc = cyc + 103;
      end else begin
        err_due  = cyc + 1;
        free_cyc = cyc + 1;
      end
    end
    prev_rom = int'(rom_addr);
  endtask

  // One clock: check at the falling edge, then return just after the next rising edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    rst_at_edge = reset;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0; step();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q.size() > 0 || cyc < free_cyc + 1) && t < 400) begin
      step(); t++;
    end
    chk("idle_timeout", 32'(t < 400), 32'd1);
  endtask

  task automatic run_cell(input bit side_b, input int x, input int y, input int g,
                          output int nwr, output int first, output int last,
                          output int nerr, output int ndone);
    int w0, e0, d0;
    bit got;
    w0 = wr_log.size(); e0 = n_err_seen; d0 = n_done_seen;
    if (side_b) begin
      req_b_valid = 1'b1; req_b_x = 6'(x); req_b_y = 6'(y); req_b_glyph = 7'(g);
    end else begin
      req_a_valid = 1'b1; req_a_x = 6'(x); req_a_y = 6'(y); req_a_glyph = 7'(g);
    end
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      step();
      got = side_b ? granted_b : granted_a;
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    chk("grant_timeout", 32'(got), 32'd1);
    wait_idle();
    nwr   = wr_log.size() - w0;
    first = (nwr > 0) ? wr_log[w0].addr : -1;
    last  = (nwr > 0) ? wr_log[wr_log.size() - 1].addr : -1;
    nerr  = n_err_seen - e0;
    ndone = n_done_seen - d0;
  endtask

  vec_t tbl[7];
  int   nwr, first, last, nerr, ndone, w0, g0, e0, d0, gaps;
  bit   got;

  initial begin
    for (int a = 0; a < 12800; a++) mem[a] = 1'($urandom);

    tbl[0] = '{1'b0,  1,  1,   0, 1'b1,   6410,  12179};
    tbl[1] = '{1'b0, 63, 47, 127, 1'b1, 301430, 307199};
    tbl[2] = '{1'b1,  5, 10,  65, 1'b1,  64050,  69819};
    tbl[3] = '{1'b0,  0,  5,   3, 1'b0,     -1,     -1};
    tbl[4] = '{1'b1,  7, 48,   3, 1'b0,     -1,     -1};
    tbl[5] = '{1'b1,  3,  0,   1, 1'b0,     -1,     -1};
    tbl[6] = '{1'b0, 32, 24, 100, 1'b1, 153920, 159689};

    // Reset state
    step(); step(); step();
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    // Single-cell vectors
    for (int i = 0; i < 7; i++) begin
      run_cell(tbl[i].side_b, tbl[i].x, tbl[i].y, tbl[i].g, nwr, first, last, nerr, ndone);
      chk($sformatf("v%0d_writes", i), nwr, tbl[i].ok ? 100 : 0);
      chk($sformatf("v%0d_first", i), first, tbl[i].first);
      chk($sformatf("v%0d_last", i), last, tbl[i].last);
      chk($sformatf("v%0d_err", i), nerr, tbl[i].ok ? 0 : 1);
      chk($sformatf("v%0d_done", i), ndone, tbl[i].ok ? 1 : 0);
    end

    // Invalid A request flips the pointer, so a following tie goes to B
    do_reset();
    w0 = wr_log.size(); e0 = n_err_seen;
    req_a_valid = 1'b1; req_a_x = 6'd5; req_a_y = 6'd48; req_a_glyph = 7'd9;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin step(); got = granted_a; end
    chk("inv_grant_a", 32'(got), 32'd1);
    req_a_x = 6'd2; req_a_y = 6'd2; req_a_glyph = 7'd1;
    req_b_valid = 1'b1; req_b_x = 6'd3; req_b_y = 6'd3; req_b_glyph = 7'd2;
    step();
    chk("tie_to_b", 32'(granted_b), 32'd1);
    chk("tie_not_a", 32'(granted_a), 32'd0);
    chk("inv_err_pulse", n_err_seen - e0, 32'd1);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    wait_idle();
    chk("inv_then_b_writes", wr_log.size() - w0, 32'd100);
    chk("inv_then_b_first", wr_log[w0].addr, 32'd19230);

    // Fairness with both requesters held valid for four cells
    do_reset();
    w0 = wr_log.size(); g0 = grant_log.size(); d0 = n_done_seen;
    req_a_valid = 1'b1; req_a_x = 6'd1; req_a_y = 6'd2; req_a_glyph = 7'd3;
    req_b_valid = 1'b1; req_b_x = 6'd4; req_b_y = 6'd5; req_b_glyph = 7'd6;
    for (int t = 0; t < 600 && grant_log.size() - g0 < 4; t++) step();
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    chk("fair_grants", grant_log.size() - g0, 32'd4);
    wait_idle();
    for (int i = 0; i < 4 && g0 + i < grant_log.size(); i++)
      chk($sformatf("fair_order%0d", i), grant_log[g0 + i], i % 2);
    chk("fair_writes", wr_log.size() - w0, 32'd400);
    chk("fair_done", n_done_seen - d0, 32'd4);
    gaps = 0;
    for (int i = w0 + 1; i < wr_log.size(); i++) begin
      if (wr_log[i].cyc - wr_log[i - 1].cyc != 1) begin
        gaps++;
        chk("fair_gap", wr_log[i].cyc - wr_log[i - 1].cyc, 32'd4);
      end
    end
    chk("fair_gap_count", gaps, 32'd3);

    // Checkerboard ROM content to expose any address/data skew at row wraps
    for (int a = 0; a < 12800; a++) mem[a] = 1'((a ^ (a / 10)) & 1);
    run_cell(1'b1, 4, 5, 77, nwr, first, last, nerr, ndone);
    chk("chk_writes", nwr, 32'd100);
    chk("chk_first", first, 32'd32040);
    chk("chk_last", last, 32'd37809);

    // Reset asserted while the 50th write is on the bus
    do_reset();
    w0 = wr_log.size(); d0 = n_done_seen;
    req_a_valid = 1'b1; req_a_x = 6'd10; req_a_y = 6'd20; req_a_glyph = 7'd33;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin step(); got = granted_a; end
    req_a_valid = 1'b0;
    chk("mid_grant", 32'(got), 32'd1);
    for (int t = 0; t < 200 && wr_log.size() - w0 < 49; t++) step();
    reset = 1'b1;
    step();
    chk("mid_fb_we", 32'(fb_we), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_writes", wr_log.size() - w0, 32'd50);
    chk("mid_no_done", n_done_seen - d0, 32'd0);
    run_cell(1'b0, 10, 20, 33, nwr, first, last, nerr, ndone);
    chk("post_writes", nwr, 32'd100);
    chk("post_first", first, 32'd128100);
    chk("post_last", last, 32'd133869);
    chk("post_done", ndone, 32'd1);

    // Randomized traffic from both requesters, valids raised and dropped at will
    for (int a = 0; a < 12800; a++) mem[a] = 1'($urandom);
    for (int n = 0; n < 3000; n++) begin
      step();
      if (granted_a || !req_a_valid) begin
        req_a_valid = ($urandom_range(2) == 0);
        req_a_x = 6'($urandom); req_a_y = 6'($urandom_range(0, 50)); req_a_glyph = 7'($urandom);
      end else if ($urandom_range(9) == 0) begin
        req_a_valid = 1'b0;
      end
      if (granted_b || !req_b_valid) begin
        req_b_valid = ($urandom_range(2) == 0);
        req_b_x = 6'($urandom); req_b_y = 6'($urandom_range(0, 50)); req_b_glyph = 7'($urandom);
      end else if ($urandom_range(9) == 0) begin
        req_b_valid = 1'b0;
      end
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    wait_idle();
    chk("rand_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_blit_scheduler.md
Name: cell_blit_scheduler

Overview:
Arbitrates character-cell draw requests from two requesters (A: local keyboard echo, B: received-message renderer) onto a single glyph-ROM / framebuffer write path. Screen is 640x480 as a linear 19-bit framebuffer of 10x10-pixel cells, with cell x in 1..63 and cell y in 1..47. For each accepted request the block walks the 100 pixels of the cell, reads a 1-bit glyph ROM, and issues one framebuffer write per cycle.

Parameters:
CELL_W, 10, cell width in pixels
CELL_H, 10, cell height in pixels
SCREEN_W, 640, framebuffer line length in pixels
ADDR_W, 19, framebuffer linear address width
GLYPH_W, 7, glyph code width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_a_valid  in  1  requester A has a cell to draw
req_a_x  in  6  A cell column
req_a_y  in  6  A cell row
req_a_glyph  in  7  A glyph code
req_a_ready  out  1  A request accepted this cycle when valid&ready
req_b_valid, req_b_x, req_b_y, req_b_glyph, req_b_ready  same as A, for requester B
rom_addr  out  14  glyph ROM address = glyph*100 + row*10 + col
rom_data  in  1  ROM pixel, valid 1 cycle after rom_addr
fb_addr  out  19  framebuffer write address
fb_data  out  1  framebuffer write pixel
fb_we  out  1  framebuffer write strobe
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse coincident with the last pixel write of a cell
err  out  1  1-cycle pulse when an invalid request is dropped

Behaviour:
- Reset values: fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, busy=0, done=0, err=0. State=IDLE. Round-robin pointer favours A.
- Reset mid-operation: abort immediately. No fb_we in the cycle after reset is sampled. The in-flight cell is left partially drawn.
- States: IDLE -> BASE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - ready is combinational and asserted only in IDLE, to exactly one requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's favourite is granted.
  - On acceptance: latch x, y, glyph; flip the pointer to the other requester.
- Validation at acceptance: x==0, y==0 or y>47 is invalid. An invalid request is still accepted (ready high) and the pointer still flips. err pulses in the next cycle, the state stays IDLE, and no ROM or fb activity occurs.
- BASE (1 cycle):
  - pix_ptr = y*6400 + x*10 (19-bit, max 301430).
  - rom_addr = glyph*100.
  - row = col = 0.
- RUN (100 cycles):
  - Each cycle presents rom_addr for pixel (row, col).
  - Next cycle: rom_addr +1. col +1; at col==9, col=0 and row +1.
  - pix_ptr advances +1 within a row and +631 at row end.
  - pix_ptr is pipelined 1 cycle to align with rom_data.
  - Leave RUN after issuing pixel (9,9).
- Write stage (registered, 1-cycle ROM latency):
  - fb_we=1, fb_addr=delayed pix_ptr, fb_data=rom_data.
  - Active from the 2nd RUN cycle through DRAIN, giving 100 consecutive writes.
- DRAIN (1 cycle): last write; done=1. Next cycle IDLE; a new grant is possible then.
- Latency: accept at cycle 0; first write at cycle 3; last write and done at cycle 102; ready again at cycle 103. Throughput is 1 cell per 103 cycles.
- Address bounds: cell (63,47) pixel (9,9) = 307199 = 640*480-1. No overflow is possible for valid input.
- The max rom_addr of 12799 fits 14 bits.
- Requests arriving while busy are held by the requester; valid may drop before ready without side effects.
- Fairness: with both requesters continuously valid, grants strictly alternate A, B, A, B.

Test Plan:
- After reset, A valid (1,1) glyph 0 with ROM model -> ready_a at cycle 0; rom_addr 0..99; 100 fb_we cycles; first fb_addr 6410, row-2 start 7050, last 12179; done at last write.
- A valid (63,47) glyph 127 -> rom_addr 12700..12799; fb_addr 301430..307199; no address exceeds 307199.
- A and B both valid from reset, held continuously, 4 cells -> grant order A,B,A,B; B never granted while busy; writes of consecutive cells separated by exactly 3 idle cycles of fb_we.
- A valid with y=48 (then x=0) -> ready_a high, err pulse next cycle, zero fb_we, next simultaneous request goes to B.
- ROM returns a checkerboard keyed on rom_addr -> each fb_data equals the ROM value for the rom_addr presented one cycle earlier; fb_addr/rom pairing correct at row wraps.
- Reset asserted during the 50th write -> fb_we=0 and busy=0 the following cycle, no done; subsequent A request draws a full cell correctly.
